// File: rtl/rsa_pkg.sv
// Shared RSA datapath constants: core field widths, field indices and the
// byte-unpacker state encoding.
package rsa_pkg;

  localparam int RSA_WORD_W     = 32;
  localparam int RSA_NUM_FIELDS = 3;

  localparam int F_KEY = 0;
  localparam int F_MOD = 1;
  localparam int F_PT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } unpack_state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rsa_word_assembler.sv
// rsa_word_assembler: staging register for one field. Bytes either shift in at the
// LSBs (MSB-first order) or land in their own byte lane (LSB-first order).
module rsa_word_assembler
  import rsa_pkg::*;
#(
  parameter int WORD_W = RSA_WORD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic              lsb_first,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] word,
  output logic              full
);

  localparam int BPW = WORD_W / 8;
  localparam int LW  = cnt_w(BPW + 1);

  logic [WORD_W-1:0] stage;
  logic [LW-1:0]     count;

  assign full = (count == LW'(BPW));

  // word already includes the byte written this cycle, so the top can latch a
  // finished field on the same edge that captures its last byte.
  always_comb begin
    word = stage;
    if (wr_en && !full) begin
      if (lsb_first) begin
        for (int b = 0; b < BPW; b++) begin
          if (count == LW'(b)) word[8*b +: 8] = data;
        end
      end else begin
        word = WORD_W'({stage, data});
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stage <= '0;
      count <= '0;
    end else if (clear) begin
      stage <= '0;
      count <= '0;
    end else if (wr_en && !full) begin
      stage <= word;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rsa_field_unpacker.sv
// rsa_field_unpacker: drains NUM_FIELDS*WORD_W/8 bytes from a non-showahead FIFO and
// assembles them into NUM_FIELDS words with runtime byte order and a stall timeout.
//
// state    | meaning
// ST_IDLE  | waiting for start; fields hold the last completed transaction
// ST_RUN   | issuing FIFO reads and capturing bytes into the field assemblers
// ST_DONE  | one-cycle done pulse; fields already updated
// ST_ABORT | one-cycle error pulse after a stall timeout
module rsa_field_unpacker
  import rsa_pkg::*;
#(
  parameter int WORD_W      = RSA_WORD_W,
  parameter int NUM_FIELDS  = RSA_NUM_FIELDS,
  parameter int FIFO_LAT    = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         lsb_first,
  input  logic [7:0]                   fifo_q,
  input  logic                         fifo_empty,
  output logic                         fifo_rdreq,
  output logic [NUM_FIELDS*WORD_W-1:0] fields,
  output logic [NUM_FIELDS-1:0]        field_valid,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int BPW         = WORD_W / 8;
  localparam int TOTAL_BYTES = NUM_FIELDS * BPW;
  localparam int CW          = cnt_w(TOTAL_BYTES + 1);
  localparam int TW          = cnt_w(TIMEOUT_CYC + 1);

  unpack_state_t state, state_nxt;

  logic [CW-1:0]                issued, captured;
  logic [FIFO_LAT-1:0]          pipe;
  logic [TW-1:0]                tmr;
  logic                         order;
  logic                         accept, cap, last_cap, tmo;
  logic [NUM_FIELDS-1:0]        wr_sel, full;
  logic [NUM_FIELDS*WORD_W-1:0] staged;

  assign accept   = (state == ST_IDLE) && start;
  assign cap      = (state == ST_RUN) && pipe[FIFO_LAT-1];
  assign last_cap = cap && (captured == CW'(TOTAL_BYTES - 1));
  assign tmo      = (TIMEOUT_CYC != 0) && !cap && (tmr == TW'(1));

  assign field_valid = full;

  always_comb begin
    state_nxt  = state;
    fifo_rdreq = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy       = 1'b1;
        fifo_rdreq = !fifo_empty && (issued < CW'(TOTAL_BYTES));
        if (last_cap)  state_nxt = ST_DONE;
        else if (tmo)  state_nxt = ST_ABORT;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ABORT: begin
        error     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      issued   <= '0;
      captured <= '0;
      pipe     <= '0;
      tmr      <= '0;
      order    <= 1'b0;
      fields   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            order    <= lsb_first;
            issued   <= '0;
            captured <= '0;
            pipe     <= '0;
            tmr      <= TW'(TIMEOUT_CYC);
          end
        end
        ST_RUN: begin
          if (fifo_rdreq) issued <= issued + 1'b1;
          pipe <= FIFO_LAT'({pipe, fifo_rdreq});
          if (cap) begin
            captured <= captured + 1'b1;
            tmr      <= TW'(TIMEOUT_CYC);
          end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end
          if (last_cap) fields <= staged;
        end
        // Reads still in flight when leaving RUN are dropped.
        default: pipe <= '0;
      endcase
    end
  end

  // Bytes fill fields in order: a field accepts only once every earlier one is full.
  for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_field
    if (k == 0) begin : g_first
      assign wr_sel[k] = cap && !full[k];
    end else begin : g_next
      assign wr_sel[k] = cap && full[k-1] && !full[k];
    end

    rsa_word_assembler #(
      .WORD_W (WORD_W)
    ) u_asm (
      .clock     (clock),
      .reset     (reset),
      .clear     (accept),
      .wr_en     (wr_sel[k]),
      .lsb_first (order),
      .data      (fifo_q),
      .word      (staged[k*WORD_W +: WORD_W]),
      .full      (full[k])
    );
  end

endmodule

// File: tb/tb_rsa_field_unpacker.sv
// Bench for rsa_field_unpacker: three instances (defaults, 16-cycle timeout, 2x64-bit)
// share one FIFO model; results are compared with a place-value byte model.
module tb_rsa_field_unpacker;
  import rsa_pkg::*;

  logic clock = 1'b0;
  always #10 clock = ~clock;

  logic         reset;
  logic         lsb_first;
  logic [2:0]   start_v = '0;
  logic [7:0]   fifo_q  = '0;
  logic [2:0]   rd_v, emp_v, busy_v, done_v, err_v;
  logic [95:0]  f0, f1;
  logic [127:0] f2;
  logic [2:0]   fv0, fv1;
  logic [1:0]   fv2;

  int          sel = 0;
  logic [7:0]  fmem [0:1023];
  logic [31:0] wp = 0;
  logic [31:0] rp = 0;
  logic        fifo_empty;
  logic [7:0]  tx [$];

  int n_chk = 0;
  int n_bad = 0;

  assign fifo_empty = (wp == rp);
  assign emp_v[0] = (sel == 0) ? fifo_empty : 1'b1;
  assign emp_v[1] = (sel == 1) ? fifo_empty : 1'b1;
  assign emp_v[2] = (sel == 2) ? fifo_empty : 1'b1;

  rsa_field_unpacker u_def (
    .clock(clock), .reset(reset), .start(start_v[0]), .lsb_first(lsb_first),
    .fifo_q(fifo_q), .fifo_empty(emp_v[0]), .fifo_rdreq(rd_v[0]), .fields(f0),
    .field_valid(fv0), .busy(busy_v[0]), .done(done_v[0]), .error(err_v[0]));

  rsa_field_unpacker #(.TIMEOUT_CYC(16)) u_tmo (
    .clock(clock), .reset(reset), .start(start_v[1]), .lsb_first(lsb_first),
    .fifo_q(fifo_q), .fifo_empty(emp_v[1]), .fifo_rdreq(rd_v[1]), .fields(f1),
    .field_valid(fv1), .busy(busy_v[1]), .done(done_v[1]), .error(err_v[1]));

  rsa_field_unpacker #(.WORD_W(64), .NUM_FIELDS(2)) u_wide (
    .clock(clock), .reset(reset), .start(start_v[2]), .lsb_first(lsb_first),
    .fifo_q(fifo_q), .fifo_empty(emp_v[2]), .fifo_rdreq(rd_v[2]), .fields(f2),
    .field_valid(fv2), .busy(busy_v[2]), .done(done_v[2]), .error(err_v[2]));

  // Non-showahead FIFO: q appears the cycle after the accepted read request.
  always @(posedge clock) begin
    if (rd_v[sel] && (wp != rp)) begin
      fifo_q <= fmem[rp[9:0]];
      rp     <= rp + 1;
    end
  end

  int cyc = 0;
  int rd_cnt   [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};
  int err_cnt  [3] = '{0, 0, 0};
  int last_rd  [3] = '{0, 0, 0};
  int over_rd = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_v[i]) begin
        rd_cnt[i]  <= rd_cnt[i] + 1;
        last_rd[i] <= cyc;
        if (emp_v[i]) over_rd <= over_rd + 1;
      end
      if (done_v[i]) done_cnt[i] <= done_cnt[i] + 1;
      if (err_v[i])  err_cnt[i]  <= err_cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] fields_of(input int i);
    case (i)
      0:       return 128'(f0);
      1:       return 128'(f1);
      default: return f2;
    endcase
  endfunction

  function automatic logic [127:0] valid_of(input int i);
    case (i)
      0:       return 128'(fv0);
      1:       return 128'(fv1);
      default: return 128'(fv2);
    endcase
  endfunction

  // Field k is the base-256 number formed by its bytes in arrival order (or reversed).
  function automatic logic [127:0] model(input int nf, input int bpw, input bit lsb);
    logic [127:0] r, b;
    int pos;
    r = '0;
    for (int k = 0; k < nf; k++) begin
      for (int j = 0; j < bpw; j++) begin
        pos = lsb ? j : bpw - 1 - j;
        b   = 128'(tx[k*bpw + j]);
        r   = r | (b << (8 * (k*bpw + pos)));
      end
    end
    return r;
  endfunction

  task automatic push(input logic [7:0] b);
    fmem[wp[9:0]] = b;
    wp = wp + 1;
  endtask

  task automatic pulse_start(input int i, input logic lsb, output int at);
    @(negedge clock);
    lsb_first  = lsb;
    start_v[i] = 1'b1;
    at = cyc;
    @(negedge clock);
    start_v[i] = 1'b0;
  endtask

  task automatic wait_pulse(input int i, input bit want_err, input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget && at < 0; n++) begin
      @(negedge clock);
      if (want_err ? err_v[i] : done_v[i]) at = cyc;
    end
    check(want_err ? "error_pulse" : "done_pulse", 128'(at >= 0), 128'(1));
    if (at >= 0)
      check("pulse_exclusive", 128'({busy_v[i], want_err ? done_v[i] : err_v[i]}), 128'(0));
  endtask

  task automatic run_txn(input int i, input bit lsb, input int gap, input bit restart,
                         input string tag);
    int nf, bpw, nb, st, at, rd0, d0, e0;
    logic [127:0] exp;
    nf  = (i == 2) ? 2 : 3;
    bpw = (i == 2) ? 8 : 4;
    nb  = nf * bpw;
    sel = i;
    rd0 = rd_cnt[i];
    d0  = done_cnt[i];
    e0  = err_cnt[i];
    if (gap == 0) foreach (tx[n]) push(tx[n]);
    pulse_start(i, lsb, st);
    if (restart) begin
      @(negedge clock);
      start_v[i] = 1'b1;
      @(negedge clock);
      start_v[i] = 1'b0;
    end
    if (gap > 0) begin
      foreach (tx[n]) begin
        repeat (gap - 1) @(negedge clock);
        push(tx[n]);
      end
    end
    wait_pulse(i, 1'b0, 200, at);
    if (gap == 0) check({tag, "_latency"}, 128'(at - st), 128'(nb + 2));
    exp = model(nf, bpw, lsb);
    check({tag, "_fields"}, fields_of(i), exp);
    check({tag, "_valid"}, valid_of(i), 128'((1 << nf) - 1));
    repeat (20) @(negedge clock);
    check({tag, "_rdreqs"}, 128'(rd_cnt[i] - rd0), 128'(nb));
    check({tag, "_done_count"}, 128'(done_cnt[i] - d0), 128'(1));
    check({tag, "_no_error"}, 128'(err_cnt[i] - e0), 128'(0));
    check({tag, "_fifo_drained"}, 128'(wp - rp), 128'(0));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] prev;
    int st, at, rd0, d0, e0;
    reset     = 1'b0;
    lsb_first = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      check("rst_ctrl", 128'({busy_v[i], done_v[i], err_v[i], rd_v[i]}), 128'(0));
      check("rst_fields", fields_of(i), 128'(0));
      check("rst_valid", valid_of(i), 128'(0));
    end
    reset = 1'b1;
    @(negedge clock);

    tx = '{8'd3, 8'd6, 8'd32, 8'd14, 8'd25, 8'd12, 8'd54, 8'd66, 8'd33, 8'd38, 8'd71, 8'd4};
    run_txn(0, 1'b0, 0, 1'b0, "t1");
    check("t1_key", 128'(f0[F_KEY*32 +: 32]), 128'(32'h0306200E));
    check("t1_mod", 128'(f0[F_MOD*32 +: 32]), 128'(32'h190C3642));
    check("t1_pt",  128'(f0[F_PT*32 +: 32]),  128'(32'h21264704));

    run_txn(0, 1'b1, 0, 1'b0, "t2");
    check("t2_key", 128'(f0[F_KEY*32 +: 32]), 128'(32'h0E200603));
    check("t2_mod", 128'(f0[F_MOD*32 +: 32]), 128'(32'h42360C19));
    check("t2_pt",  128'(f0[F_PT*32 +: 32]),  128'(32'h04472621));

    run_txn(0, 1'b0, 5, 1'b0, "t3");
    check("t3_key", 128'(f0[F_KEY*32 +: 32]), 128'(32'h0306200E));
    check("t3_pt",  128'(f0[F_PT*32 +: 32]),  128'(32'h21264704));

    for (int it = 0; it < 8; it++) begin
      int i, nb, gap;
      i   = int'($urandom_range(0, 2));
      nb  = (i == 2) ? 16 : 12;
      gap = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
      tx.delete();
      for (int n = 0; n < nb; n++) tx.push_back(8'($urandom));
      run_txn(i, 1'($urandom), gap, 1'b0, "rnd");
    end

    tx.delete();
    for (int n = 0; n < 12; n++) tx.push_back(8'($urandom));
    run_txn(1, 1'b0, 0, 1'b0, "t4_pre");
    prev = 128'(f1);
    tx.delete();
    for (int n = 0; n < 6; n++) tx.push_back(8'($urandom));
    sel = 1;
    rd0 = rd_cnt[1];
    d0  = done_cnt[1];
    e0  = err_cnt[1];
    foreach (tx[n]) push(tx[n]);
    pulse_start(1, 1'b0, st);
    wait_pulse(1, 1'b1, 300, at);
    check("t4_error_delay", 128'(at - last_rd[1]), 128'(18));
    check("t4_valid", 128'(fv1), 128'(3'b001));
    check("t4_fields_kept", 128'(f1), prev);
    repeat (5) @(negedge clock);
    check("t4_valid_held", 128'(fv1), 128'(3'b001));
    check("t4_busy", 128'(busy_v[1]), 128'(0));
    check("t4_rdreqs", 128'(rd_cnt[1] - rd0), 128'(6));
    check("t4_err_count", 128'(err_cnt[1] - e0), 128'(1));
    check("t4_no_done", 128'(done_cnt[1] - d0), 128'(0));

    sel = 0;
    rd0 = rd_cnt[0];
    for (int n = 0; n < 5; n++) push(8'($urandom));
    pulse_start(0, 1'b0, st);
    for (int n = 0; n < 60 && (rd_cnt[0] - rd0) < 5; n++) @(negedge clock);
    repeat (4) @(negedge clock);
    check("t5_reads_before_reset", 128'(rd_cnt[0] - rd0), 128'(5));
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("t5_rst_ctrl", 128'({busy_v[0], done_v[0], err_v[0], rd_v[0]}), 128'(0));
    check("t5_rst_fields", 128'(f0), 128'(0));
    check("t5_rst_valid", 128'(fv0), 128'(0));
    tx.delete();
    for (int n = 1; n <= 12; n++) tx.push_back(8'(n));
    run_txn(0, 1'b0, 0, 1'b0, "t5");
    check("t5_key", 128'(f0[F_KEY*32 +: 32]), 128'(32'h01020304));
    check("t5_mod", 128'(f0[F_MOD*32 +: 32]), 128'(32'h05060708));
    check("t5_pt",  128'(f0[F_PT*32 +: 32]),  128'(32'h090A0B0C));

    tx.delete();
    for (int n = 0; n < 16; n++) tx.push_back(8'(n));
    run_txn(2, 1'b0, 0, 1'b1, "t6");
    check("t6_field0", 128'(f2[63:0]),   128'(64'h0001020304050607));
    check("t6_field1", 128'(f2[127:64]), 128'(64'h08090A0B0C0D0E0F));

    check("no_read_while_empty", 128'(over_rd), 128'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
